// File: rtl/elastic_pipe_pkg.sv
// Shared constants and helpers for the elastic pipeline.
// Holds the stage-count ceiling and the even-parity function used when ELASTIC_PIPE_PARITY_EN is defined.
package elastic_pipe_pkg;

  localparam int DEPTH_MAX = 16;
  localparam int PAR_MAX_W = 64;

  // Even parity bit: XOR of all bits, so data plus parity has an even number of ones.
  function automatic logic even_parity(input logic [PAR_MAX_W-1:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/pipe_stage.sv
// One elastic pipeline stage: a valid bit, a payload register and the ready chain.
// The stage loads whenever it is empty or its current beat moves on this cycle.
module pipe_stage #(
  parameter int SW = 8
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          flush,
  input  logic          up_valid,
  input  logic [SW-1:0] up_data,
  input  logic          down_ready,
  output logic          valid,
  output logic [SW-1:0] data,
  output logic          ready
);

  assign ready = !valid || down_ready;

  // Flush clears only the valid bit; the payload keeps its last value.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (ready) begin
      valid <= up_valid;
      if (up_valid) data <= up_data;
    end
  end

endmodule

// File: rtl/elastic_pipe.sv
// Elastic register pipeline of DEPTH stages with valid/ready handshakes on both sides.
// Define ELASTIC_PIPE_PARITY_EN to carry an even-parity bit per stage and flag mismatches on par_err.
module elastic_pipe
  import elastic_pipe_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       flush,
  input  logic                       in_valid,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [WIDTH-1:0]           out_data,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] occupancy,
  output logic                       par_err
);

  localparam int OCC_W = $clog2(DEPTH+1);
`ifdef ELASTIC_PIPE_PARITY_EN
  localparam int SW = WIDTH + 1;
`else
  localparam int SW = WIDTH;
`endif

  if (DEPTH < 1 || DEPTH > DEPTH_MAX) begin : g_bad_depth
    $error("elastic_pipe: DEPTH out of range");
  end

  logic [SW-1:0] stage_in;
  logic          in_xfer;
  logic          out_xfer;

`ifdef ELASTIC_PIPE_PARITY_EN
  assign stage_in = {even_parity(PAR_MAX_W'(in_data)), in_data};
`else
  assign stage_in = in_data;
`endif

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    logic          v;
    logic          r;
    logic          uv;
    logic          dn_ready;
    logic [SW-1:0] d;
    logic [SW-1:0] ud;

    if (k == 0) begin : g_first
      assign uv = in_valid;
      assign ud = stage_in;
    end else begin : g_chain
      assign uv = g_stage[k-1].v;
      assign ud = g_stage[k-1].d;
    end

    if (k == DEPTH-1) begin : g_last
      assign dn_ready = out_ready;
    end else begin : g_mid
      assign dn_ready = g_stage[k+1].r;
    end

    pipe_stage #(.SW(SW)) u_stage (
      .clk        (clk),
      .rstn       (rstn),
      .flush      (flush),
      .up_valid   (uv),
      .up_data    (ud),
      .down_ready (dn_ready),
      .valid      (v),
      .data       (d),
      .ready      (r)
    );
  end

  assign in_ready  = g_stage[0].r && !flush;
  assign out_valid = g_stage[DEPTH-1].v;
  assign out_data  = g_stage[DEPTH-1].d[WIDTH-1:0];
  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = out_valid && out_ready;

  // Simultaneous push and pop leave the count unchanged; flush wins over both.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      occupancy <= '0;
    end else if (flush) begin
      occupancy <= '0;
    end else if (in_xfer && !out_xfer) begin
      occupancy <= occupancy + OCC_W'(1);
    end else if (out_xfer && !in_xfer) begin
      occupancy <= occupancy - OCC_W'(1);
    end
  end

`ifdef ELASTIC_PIPE_PARITY_EN
  // Checked on every output transfer, including one that coincides with a flush.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      par_err <= 1'b0;
    end else begin
      par_err <= out_xfer &&
                 (even_parity(PAR_MAX_W'(out_data)) != g_stage[DEPTH-1].d[WIDTH]);
    end
  end
`else
  assign par_err = 1'b0;
`endif

endmodule

// File: tb/tb_elastic_pipe.sv
// Directed self-checking bench for elastic_pipe (WIDTH=8, DEPTH=4).
// The parity corruption scenario is compiled only when ELASTIC_PIPE_PARITY_EN is defined.
module tb_elastic_pipe;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             rstn;
  logic             flush;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;
  logic [2:0]       occupancy;
  logic             par_err;

  int checks = 0;
  int fails  = 0;

  elastic_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .occupancy (occupancy),
    .par_err   (par_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    #3;
    checks++; if (out_valid !== 1'b0) begin fails++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (occupancy !== 3'd0) begin fails++; $display("[TB] FAIL reset_occupancy: got %0d expected 0", occupancy); end
    checks++; if (in_ready !== 1'b1) begin fails++; $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready); end
    checks++; if (out_data !== 8'h00) begin fails++; $display("[TB] FAIL reset_out_data: got %h expected 00", out_data); end
    checks++; if (par_err !== 1'b0) begin fails++; $display("[TB] FAIL reset_par_err: got %b expected 0", par_err); end
    #10 rstn = 1'b1;
    tick();
  endtask

  // 0x01..0x10 back to back; beat accepted at edge c shows at the output after edge c+3.
  task automatic test_stream();
    int exp_occ;
    out_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      in_valid = (c < 16);
      in_data  = 8'(c + 1);
      if (c < 16) begin
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin fails++; $display("[TB] FAIL stream_in_ready c=%0d: got %b expected 1", c, in_ready); end
      end
      tick();
      exp_occ = ((c + 1 < 16) ? c + 1 : 16) - ((c > 3) ? c - 3 : 0);
      checks++; if (out_valid !== (c >= 3 && c < 19)) begin fails++; $display("[TB] FAIL stream_out_valid c=%0d: got %b expected %b", c, out_valid, (c >= 3 && c < 19)); end
      if (c >= 3 && c < 19) begin
        checks++; if (out_data !== 8'(c - 2)) begin fails++; $display("[TB] FAIL stream_out_data c=%0d: got %h expected %h", c, out_data, 8'(c - 2)); end
      end
      checks++; if (occupancy !== 3'(exp_occ)) begin fails++; $display("[TB] FAIL stream_occupancy c=%0d: got %0d expected %0d", c, occupancy, exp_occ); end
    end
    in_valid = 1'b0;
  endtask

  // out_ready low: six beats offered, only four fit, first beat held at the output.
  task automatic test_backpressure();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_data = 8'hA0 + 8'((i < 4) ? i : 4);
      @(negedge clk);
      checks++; if (in_ready !== (i < 4)) begin fails++; $display("[TB] FAIL bp_in_ready i=%0d: got %b expected %b", i, in_ready, (i < 4)); end
      tick();
      checks++; if (occupancy !== 3'((i < 4) ? i + 1 : 4)) begin fails++; $display("[TB] FAIL bp_occupancy i=%0d: got %0d expected %0d", i, occupancy, (i < 4) ? i + 1 : 4); end
      if (i >= 3) begin
        checks++; if (out_valid !== 1'b1 || out_data !== 8'hA0) begin fails++; $display("[TB] FAIL bp_out_hold i=%0d: got %b/%h expected 1/a0", i, out_valid, out_data); end
      end
    end
    in_valid = 1'b0;
  endtask

  // Full pipe, both sides active for five cycles, then drain.
  task automatic test_back_to_back();
    logic [7:0] exp_out [9];
    exp_out = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hB0, 8'hB1, 8'hB2, 8'hB3, 8'hB4};
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = 8'hB0 + 8'(i);
      @(negedge clk);
      checks++; if (in_ready !== 1'b1) begin fails++; $display("[TB] FAIL b2b_in_ready i=%0d: got %b expected 1", i, in_ready); end
      checks++; if (out_valid !== 1'b1 || out_data !== exp_out[i]) begin fails++; $display("[TB] FAIL b2b_out i=%0d: got %b/%h expected 1/%h", i, out_valid, out_data, exp_out[i]); end
      tick();
      checks++; if (occupancy !== 3'd4) begin fails++; $display("[TB] FAIL b2b_occupancy i=%0d: got %0d expected 4", i, occupancy); end
    end
    in_valid = 1'b0;
    for (int i = 5; i < 9; i++) begin
      @(negedge clk);
      checks++; if (out_valid !== 1'b1 || out_data !== exp_out[i]) begin fails++; $display("[TB] FAIL drain_out i=%0d: got %b/%h expected 1/%h", i, out_valid, out_data, exp_out[i]); end
      tick();
    end
    checks++; if (occupancy !== 3'd0 || out_valid !== 1'b0) begin fails++; $display("[TB] FAIL drain_empty: got %0d/%b expected 0/0", occupancy, out_valid); end
  endtask

  // Three beats held, then a flush cycle with a beat offered at the input.
  task automatic test_flush();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = 8'hC0 + 8'(i);
      tick();
    end
    checks++; if (occupancy !== 3'd3) begin fails++; $display("[TB] FAIL flush_pre_occ: got %0d expected 3", occupancy); end
    flush   = 1'b1;
    in_data = 8'hC3;
    @(negedge clk);
    checks++; if (in_ready !== 1'b0) begin fails++; $display("[TB] FAIL flush_in_ready: got %b expected 0", in_ready); end
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    checks++; if (occupancy !== 3'd0) begin fails++; $display("[TB] FAIL flush_occupancy: got %0d expected 0", occupancy); end
    checks++; if (out_valid !== 1'b0) begin fails++; $display("[TB] FAIL flush_out_valid: got %b expected 0", out_valid); end
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (out_valid !== 1'b0 || occupancy !== 3'd0) begin fails++; $display("[TB] FAIL flush_no_beat i=%0d: got %b/%0d expected 0/0", i, out_valid, occupancy); end
    end
  endtask

  // Reset dropped between edges mid-stream, then released with a beat waiting.
  task automatic test_async_reset();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_data = 8'hD0 + 8'(i);
      tick();
    end
    #2 rstn = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin fails++; $display("[TB] FAIL arst_out_valid: got %b expected 0", out_valid); end
    checks++; if (occupancy !== 3'd0) begin fails++; $display("[TB] FAIL arst_occupancy: got %0d expected 0", occupancy); end
    checks++; if (in_ready !== 1'b1) begin fails++; $display("[TB] FAIL arst_in_ready: got %b expected 1", in_ready); end
    in_data = 8'hD5;
    @(negedge clk);
    rstn = 1'b1;
    tick();
    in_valid = 1'b0;
    checks++; if (occupancy !== 3'd1) begin fails++; $display("[TB] FAIL arst_first_accept: got %0d expected 1", occupancy); end
    tick(); tick(); tick();
    checks++; if (out_valid !== 1'b1 || out_data !== 8'hD5) begin fails++; $display("[TB] FAIL arst_first_out: got %b/%h expected 1/d5", out_valid, out_data); end
    tick();
    checks++; if (out_valid !== 1'b0) begin fails++; $display("[TB] FAIL arst_no_stale: got %b expected 0", out_valid); end
  endtask

  task automatic test_parity();
`ifdef ELASTIC_PIPE_PARITY_EN
    logic [WIDTH:0] corrupt;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = 8'hE0 + 8'(i);
      tick();
    end
    in_valid = 1'b0;
    corrupt = dut.g_stage[2].u_stage.data ^ 9'h004;
    force dut.g_stage[2].u_stage.data = corrupt;
    #1;
    release dut.g_stage[2].u_stage.data;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (par_err !== (i == 1)) begin fails++; $display("[TB] FAIL parity_pulse i=%0d: got %b expected %b", i, par_err, (i == 1)); end
    end
`else
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_data = 8'h5A ^ 8'(i * 37);
      tick();
      checks++; if (par_err !== 1'b0) begin fails++; $display("[TB] FAIL parity_tied i=%0d: got %b expected 0", i, par_err); end
    end
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) tick();
`endif
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_back_to_back();
    test_flush();
    test_async_reset();
    test_parity();
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule

// File: doc/elastic_pipe.md
ELASTIC_PIPE -- requirements
Module: elastic_pipe

Interface
REQ-001 The block SHALL have these parameters:
  WIDTH  8  payload bits per beat
  DEPTH  4  register stages, legal range 1..16
REQ-002 The block SHALL have these ports:
  clk        input   1                      clock, all state on rising edge
  rstn       input   1                      reset, asynchronous, active-low
  flush      input   1                      synchronous clear of all stages
  in_valid   input   1                      upstream beat present
  in_data    input   WIDTH                  upstream payload
  in_ready   output  1                      block accepts beat this cycle
  out_valid  output  1                      beat present at last stage
  out_data   output  WIDTH                  payload of last stage
  out_ready  input   1                      downstream takes beat this cycle
  occupancy  output  $clog2(DEPTH+1)        number of valid stages
  par_err    output  1                      parity mismatch pulse at output

Function
REQ-003 The block SHALL be a chain of DEPTH stages, each holding one valid bit and one WIDTH payload.
REQ-004 A transfer SHALL occur on a side when valid and ready are both high at a rising clk edge.
REQ-005 Stage k SHALL load from stage k-1 (stage 0 from input) when it is empty or its contents move forward in the same cycle.
REQ-006 Stage ready SHALL be combinational: ready(k) = !valid(k) || ready(k+1); ready of last stage = out_ready; in_ready = ready(0) && !flush.
REQ-007 With out_ready held high, a beat accepted at edge N SHALL appear on out_valid/out_data after edge N+DEPTH-1 (latency DEPTH cycles, throughput one beat per cycle).
REQ-008 When out_ready is low, out_valid and out_data SHALL hold stable; beats SHALL compress into empty stages until all DEPTH stages are full, then in_ready SHALL be low.
REQ-009 Beat order SHALL be preserved; no beat SHALL be dropped or duplicated except by flush or reset.
REQ-010 out_data SHALL be driven only from the last stage register (no combinational path from in_data).
REQ-011 occupancy SHALL be a registered count of valid stages: +1 on input transfer only, -1 on output transfer only, unchanged when both or neither occur.
REQ-012 flush high at an edge SHALL clear every valid bit and occupancy to 0; no input transfer occurs that cycle; an output transfer asserted the same cycle SHALL still count as taken by downstream.
REQ-013 Payload registers SHALL NOT be cleared by flush (valid bits only).

Reset
REQ-014 rstn low SHALL asynchronously clear all valid bits, all payload registers, occupancy and par_err to 0; in_ready SHALL be high and out_valid low while in reset.
REQ-015 Reset assertion mid-transfer SHALL discard all in-flight beats; first acceptance after release SHALL occur at the first edge with rstn high.

Configuration
REQ-016 Macro ELASTIC_PIPE_PARITY_EN SHALL compile in parity protection: each stage carries an extra even-parity bit generated from in_data at acceptance.
REQ-017 With the macro defined, par_err SHALL be a registered one-cycle pulse following any edge where out_valid && out_ready and recomputed parity of out_data differs from the carried bit.
REQ-018 Without the macro, no parity storage SHALL exist and par_err SHALL be tied to 0; all other behaviour identical.

Structure
REQ-019 A shared package elastic_pipe_pkg SHALL hold DEPTH_MAX (16) and the parity function.
REQ-020 One sub-module pipe_stage (one valid bit, one payload register, ready logic) SHALL be instantiated DEPTH times via generate.

Verification
REQ-021 DEPTH=4, out_ready=1, stream 0x01..0x10 back to back -> 0x01 at out after 4 cycles, then one beat per cycle, in order.
REQ-022 out_ready=0, push 6 beats -> in_ready low after 4 accepted, occupancy=4, out_data=first beat held stable.
REQ-023 Full pipe, out_ready and in_valid both high for 5 cycles -> occupancy stays 4, 5 beats out, 5 in.
REQ-024 Pipe with 3 beats, flush pulse with in_valid high -> occupancy=0, out_valid low next cycle, flushed input not accepted.
REQ-025 rstn pulsed low mid-stream (async, between edges) -> out_valid and occupancy 0 immediately, in_ready high.
REQ-026 With ELASTIC_PIPE_PARITY_EN, force one payload bit flip in stage 2 -> par_err=1 for exactly one cycle after that beat's output transfer.
